// File: rtl/axi4_mem_pkg.sv
// Shared types and helpers for the AXI4 memory responder.
// Burst/response encodings, FSM state types and WRAP length legality.
package axi4_mem_pkg;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_e;
  typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Combinational AXI4 burst address stepper: next beat address, memory word
// index of the current address, and command/range error flags.
module axi4_burst_addr
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic [MEM_AW-1:0] mem_idx,
  output logic              range_err,
  output logic              cmd_err
);

  localparam int                BYTE_W   = $clog2(DATA_W / 8);
  localparam logic [2:0]        SIZE_MAX = 3'(BYTE_W);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] step_s;
  logic [ADDR_W-1:0] incr_s;
  logic [ADDR_W-1:0] wrap_mask_s;
  logic [ADDR_W-1:0] word_s;

  // INCR steps from the size-aligned address; WRAP keeps the aligned-down window base
  always_comb begin
    step_s      = ONE_A << size;
    incr_s      = (addr & ~(step_s - ONE_A)) + step_s;
    wrap_mask_s = ((ADDR_W'({1'b0, len}) + ONE_A) << size) - ONE_A;
    word_s      = addr >> BYTE_W;
    case (burst)
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr_s;
      WRAP:    next_addr = (addr & ~wrap_mask_s) | (incr_s & wrap_mask_s);
      default: next_addr = addr;
    endcase
    mem_idx   = word_s[MEM_AW-1:0];
    range_err = (word_s >= DEPTH_A);
    cmd_err   = (size > SIZE_MAX) || (burst == 2'b11) ||
                ((burst == WRAP) && !wrap_len_ok(len));
  end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by an internal word-addressed memory; one write burst and
// one read burst in flight, with independent write and read FSMs.
module axi4_mem_responder
  import axi4_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  wr_state_e         wr_state_r;
  logic [ID_W-1:0]   wr_id_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_len_r, wr_beat_r;
  logic [2:0]        wr_size_r;
  logic [1:0]        wr_burst_r;
  logic              wr_err_r;
  logic              awready_r, wready_r, bvalid_r;
  logic [ID_W-1:0]   bid_r;
  logic [1:0]        bresp_r;

  rd_state_e         rd_state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [7:0]        rd_len_r, rd_beat_r;
  logic [2:0]        rd_size_r;
  logic [1:0]        rd_burst_r;
  logic              arready_r, rvalid_r, rlast_r;
  logic [ID_W-1:0]   rid_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        rresp_r;

  logic [ADDR_W-1:0] wr_next_s, rd_next_s, rd_cmd_addr_s;
  logic [MEM_AW-1:0] wr_idx_s, rd_idx_s;
  logic              wr_range_err_s, wr_cmd_err_s, rd_range_err_s, rd_cmd_err_s;
  logic              wr_beat_err_s, wr_last_beat_s, wr_en_s, rd_bad_s;
  logic [7:0]        rd_cmd_len_s;
  logic [2:0]        rd_cmd_size_s;
  logic [1:0]        rd_cmd_burst_s, rd_resp_s;
  logic [DATA_W-1:0] rd_word_s;

  axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_wr_addr (
    .addr(wr_addr_r), .len(wr_len_r), .size(wr_size_r), .burst(wr_burst_r),
    .next_addr(wr_next_s), .mem_idx(wr_idx_s), .range_err(wr_range_err_s), .cmd_err(wr_cmd_err_s)
  );

  // While idle the read stepper looks at the AR channel so beat 0 loads on the AR handshake
  assign rd_cmd_addr_s  = (rd_state_r == R_IDLE) ? araddr  : rd_addr_r;
  assign rd_cmd_len_s   = (rd_state_r == R_IDLE) ? arlen   : rd_len_r;
  assign rd_cmd_size_s  = (rd_state_r == R_IDLE) ? arsize  : rd_size_r;
  assign rd_cmd_burst_s = (rd_state_r == R_IDLE) ? arburst : rd_burst_r;

  axi4_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_rd_addr (
    .addr(rd_cmd_addr_s), .len(rd_cmd_len_s), .size(rd_cmd_size_s), .burst(rd_cmd_burst_s),
    .next_addr(rd_next_s), .mem_idx(rd_idx_s), .range_err(rd_range_err_s), .cmd_err(rd_cmd_err_s)
  );

  assign wr_beat_err_s  = wr_cmd_err_s | wr_range_err_s;
  assign wr_last_beat_s = (wr_beat_r == wr_len_r);
  assign wr_en_s        = (wr_state_r == W_DATA) && wvalid && !wr_beat_err_s;
  assign rd_bad_s       = rd_cmd_err_s | rd_range_err_s;
  assign rd_word_s      = rd_bad_s ? {DATA_W{1'b0}} : mem_r[rd_idx_s];
  assign rd_resp_s      = rd_bad_s ? SLVERR : OKAY;

  // Byte-enable memory write port
  always_ff @(posedge aclk) begin
    if (wr_en_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_r[wr_idx_s][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: AW latch, W beats, B response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_r <= W_IDLE;
      wr_id_r    <= '0;
      wr_addr_r  <= '0;
      wr_len_r   <= 8'd0;
      wr_beat_r  <= 8'd0;
      wr_size_r  <= 3'd0;
      wr_burst_r <= 2'd0;
      wr_err_r   <= 1'b0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bid_r      <= '0;
      bresp_r    <= 2'b00;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (awready_r && awvalid) begin
            wr_id_r    <= awid;
            wr_addr_r  <= awaddr;
            wr_len_r   <= awlen;
            wr_size_r  <= awsize;
            wr_burst_r <= awburst;
            wr_beat_r  <= 8'd0;
            wr_err_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b1;
            wr_state_r <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            if (wr_last_beat_s || wlast) begin
              wready_r   <= 1'b0;
              bvalid_r   <= 1'b1;
              bid_r      <= wr_id_r;
              bresp_r    <= (wr_err_r || wr_beat_err_s || (wlast != wr_last_beat_s)) ? SLVERR : OKAY;
              wr_state_r <= W_RESP;
            end else begin
              wr_beat_r <= wr_beat_r + 8'd1;
              wr_addr_r <= wr_next_s;
              wr_err_r  <= wr_err_r | wr_beat_err_s;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wr_state_r <= W_IDLE;
          end
        end
        default: wr_state_r <= W_IDLE;
      endcase
    end
  end

  // Read FSM: AR latch, then one registered beat per R handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_r <= R_IDLE;
      rd_addr_r  <= '0;
      rd_len_r   <= 8'd0;
      rd_beat_r  <= 8'd0;
      rd_size_r  <= 3'd0;
      rd_burst_r <= 2'd0;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      rid_r      <= '0;
      rdata_r    <= '0;
      rresp_r    <= 2'b00;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (arready_r && arvalid) begin
            rd_len_r   <= arlen;
            rd_size_r  <= arsize;
            rd_burst_r <= arburst;
            rd_beat_r  <= 8'd0;
            rd_addr_r  <= rd_next_s;
            rid_r      <= arid;
            rdata_r    <= rd_word_s;
            rresp_r    <= rd_resp_s;
            rlast_r    <= (arlen == 8'd0);
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rd_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_r) begin
              rvalid_r   <= 1'b0;
              rlast_r    <= 1'b0;
              arready_r  <= 1'b1;
              rd_state_r <= R_IDLE;
            end else begin
              rd_beat_r <= rd_beat_r + 8'd1;
              rd_addr_r <= rd_next_s;
              rdata_r   <= rd_word_s;
              rresp_r   <= rd_resp_s;
              rlast_r   <= ((rd_beat_r + 8'd1) == rd_len_r);
            end
          end
        end
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rid     = rid_r;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rlast   = rlast_r;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: a single-beat vector table plus
// hand-written burst, error and reset sequences.
module tb_axi4_mem_responder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wbeats [16];
  logic [3:0]  wstrbs [16];
  logic [31:0] rbeats [16];
  logic [1:0]  rresps [16];
  logic        rlasts [16];

  typedef struct {
    logic [15:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  wstb;
    logic [1:0]  exp_bresp;
    logic [15:0] raddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;
  vec_t vecs [10];

  always #5 aclk = ~aclk;

  axi4_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_beat,
                          output logic [1:0] resp);
    int k;
    int nb;
    nb = (wlast_beat < int'(len)) ? wlast_beat + 1 : int'(len) + 1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    k = 0;
    while (!awready && k < 20) begin @(negedge aclk); k++; end
    if (k == 20) timeout("aw_wait");
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata = wbeats[i]; wstrb = wstrbs[i]; wlast = (i == wlast_beat); wvalid = 1'b1;
      k = 0;
      while (!wready && k < 20) begin @(negedge aclk); k++; end
      if (k == 20) timeout("w_wait");
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    k = 0;
    while (!bvalid && k < 20) begin @(negedge aclk); k++; end
    check("b_latency", k, 0);
    check("bid", bid, id);
    resp = bresp;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
    check("awready_idle", awready, 1'b1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int k;
    int got;
    int cyc;
    bit stalled;
    logic [31:0] held;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 20) begin @(negedge aclk); k++; end
    if (k == 20) timeout("ar_wait");
    @(negedge aclk);
    arvalid = 1'b0;
    check("r_first_latency", rvalid, 1'b1);
    got = 0; cyc = 0; stalled = 1'b0; held = 32'h0;
    while (got <= int'(len) && cyc < 100) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid) begin
        if (stalled) check("r_stable", rdata, held);
        if (rready) begin
          check("rid", rid, id);
          rbeats[got] = rdata; rresps[got] = rresp; rlasts[got] = rlast;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = rdata;
        end
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    if (got <= int'(len)) timeout("r_beats");
    check("r_done", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    logic [1:0] resp;
    aresetn = 1'b0;
    awid = 4'h0; awaddr = 16'h0; awlen = 8'h0; awsize = 3'd0; awburst = 2'b00; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 4'h0; araddr = 16'h0; arlen = 8'h0; arsize = 3'd0; arburst = 2'b00; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_b", {bid, bresp}, 6'h0);
    check("rst_r", {rid, rdata, rresp, rlast}, 39'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("awready_after_rst", awready, 1'b1);
    check("arready_after_rst", arready, 1'b1);

    vecs[0] = '{16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0010, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{16'h0000, 32'h0BADF00D, 4'hF, 2'b00, 16'h0000, 32'h0BADF00D, 2'b00};
    vecs[2] = '{16'h0044, 32'hFFFFFFFF, 4'hF, 2'b00, 16'h0044, 32'hFFFFFFFF, 2'b00};
    vecs[3] = '{16'h0044, 32'h00000000, 4'h5, 2'b00, 16'h0044, 32'hFF00FF00, 2'b00};
    vecs[4] = '{16'h1000, 32'h12345678, 4'hF, 2'b10, 16'h0000, 32'h0BADF00D, 2'b00};
    vecs[5] = '{16'h1000, 32'h00000000, 4'hF, 2'b10, 16'h1000, 32'h00000000, 2'b10};
    vecs[6] = '{16'h0FFC, 32'hA5A5A5A5, 4'hF, 2'b00, 16'h0FFC, 32'hA5A5A5A5, 2'b00};
    vecs[7] = '{16'h0010, 32'h11223344, 4'h8, 2'b00, 16'h0010, 32'h11ADBEEF, 2'b00};
    vecs[8] = '{16'h0010, 32'h000000AA, 4'h1, 2'b00, 16'h0010, 32'h11ADBEAA, 2'b00};
    vecs[9] = '{16'hFFFC, 32'h00000000, 4'hF, 2'b10, 16'hFFFC, 32'h00000000, 2'b10};

    for (int v = 0; v < 10; v++) begin
      wbeats[0] = vecs[v].wdat;
      wstrbs[0] = vecs[v].wstb;
      do_write(4'(v), vecs[v].waddr, 8'd0, 3'd2, 2'b01, 0, resp);
      check($sformatf("vec%0d_bresp", v), resp, vecs[v].exp_bresp);
      do_read(4'(v + 1), vecs[v].raddr, 8'd0, 3'd2, 2'b01, 1'b0);
      check($sformatf("vec%0d_rdata", v), rbeats[0], vecs[v].exp_rdata);
      check($sformatf("vec%0d_rresp", v), rresps[0], vecs[v].exp_rresp);
      check($sformatf("vec%0d_rlast", v), rlasts[0], 1'b1);
    end

    // INCR 4 beats, read back with rready toggling
    for (int i = 0; i < 4; i++) begin wbeats[i] = 32'hA0000000 + 32'(i); wstrbs[i] = 4'hF; end
    do_write(4'h1, 16'h0020, 8'd3, 3'd2, 2'b01, 3, resp);
    check("incr_bresp", resp, 2'b00);
    do_read(4'h2, 16'h0020, 8'd3, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rbeats[i], 32'hA0000000 + 32'(i));
      check($sformatf("incr_rlast%0d", i), rlasts[i], (i == 3));
      check($sformatf("incr_rresp%0d", i), rresps[i], 2'b00);
    end

    // INCR read running off the end of memory: second beat errs alone
    do_read(4'h3, 16'h0FFC, 8'd1, 3'd2, 2'b01, 1'b0);
    check("edge_rdata0", rbeats[0], 32'hA5A5A5A5);
    check("edge_rresp0", rresps[0], 2'b00);
    check("edge_rdata1", rbeats[1], 32'h0);
    check("edge_rresp1", rresps[1], 2'b10);

    // WRAP len=3 at 0x38 lands on 0x38, 0x3C, 0x30, 0x34
    for (int i = 0; i < 4; i++) begin wbeats[i] = 32'hB0B00000 + 32'(i); wstrbs[i] = 4'hF; end
    do_write(4'h4, 16'h0038, 8'd3, 3'd2, 2'b10, 3, resp);
    check("wrap_bresp", resp, 2'b00);
    for (int i = 0; i < 4; i++) begin
      do_read(4'h5, 16'h0030 + 16'(((i + 2) % 4) * 4), 8'd0, 3'd2, 2'b01, 1'b0);
      check($sformatf("wrap_single%0d", i), rbeats[0], 32'hB0B00000 + 32'(i));
    end
    do_read(4'h6, 16'h0038, 8'd3, 3'd2, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_burst%0d", i), rbeats[i], 32'hB0B00000 + 32'(i));

    // Oversized beat: SLVERR, no write, read data zero
    wbeats[0] = 32'h5A5A5A5A; wstrbs[0] = 4'hF;
    do_write(4'h7, 16'h0050, 8'd0, 3'd2, 2'b01, 0, resp);
    check("size_pre_bresp", resp, 2'b00);
    wbeats[0] = 32'hFFFFFFFF;
    do_write(4'h8, 16'h0050, 8'd0, 3'd3, 2'b01, 0, resp);
    check("size3_bresp", resp, 2'b10);
    do_read(4'h9, 16'h0050, 8'd0, 3'd2, 2'b01, 1'b0);
    check("size3_nowrite", rbeats[0], 32'h5A5A5A5A);
    do_read(4'h9, 16'h0050, 8'd0, 3'd3, 2'b01, 1'b0);
    check("size3_rdata", rbeats[0], 32'h0);
    check("size3_rresp", rresps[0], 2'b10);

    // Misplaced wlast: early on beat 1 of len=3, and absent on len=1
    for (int i = 0; i < 4; i++) begin wbeats[i] = 32'h60600000 + 32'(i); wstrbs[i] = 4'hF; end
    do_write(4'hA, 16'h0060, 8'd3, 3'd2, 2'b01, 1, resp);
    check("early_wlast_bresp", resp, 2'b10);
    do_write(4'hB, 16'h0060, 8'd1, 3'd2, 2'b01, 99, resp);
    check("no_wlast_bresp", resp, 2'b10);
    wbeats[0] = 32'h60606060;
    do_write(4'hC, 16'h0060, 8'd0, 3'd2, 2'b01, 0, resp);
    check("after_err_bresp", resp, 2'b00);

    // Illegal burst type and illegal WRAP length
    wbeats[0] = 32'h77777777;
    do_write(4'hD, 16'h0060, 8'd0, 3'd2, 2'b11, 0, resp);
    check("burst11_bresp", resp, 2'b10);
    do_write(4'hE, 16'h0060, 8'd2, 3'd2, 2'b10, 2, resp);
    check("wrap_len2_bresp", resp, 2'b10);
    do_read(4'hF, 16'h0060, 8'd0, 3'd2, 2'b01, 1'b0);
    check("bad_burst_nowrite", rbeats[0], 32'h60606060);

    // Reset pulse with both directions mid-burst
    awaddr = 16'h0080; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    araddr = 16'h0010; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; arvalid = 1'b0;
    wdata = 32'h12121212; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge aclk);
    check("mid_wready", wready, 1'b1);
    check("mid_rvalid", rvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check("arst_wready", wready, 1'b0);
    check("arst_rvalid", rvalid, 1'b0);
    check("arst_bvalid", bvalid, 1'b0);
    check("arst_readies", {awready, arready}, 2'b00);
    wvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_readies", {awready, arready, wready}, 3'b110);
    wbeats[0] = 32'hC0FFEE00; wstrbs[0] = 4'hF;
    do_write(4'h3, 16'h0080, 8'd0, 3'd2, 2'b01, 0, resp);
    check("post_rst_bresp", resp, 2'b00);
    do_read(4'h4, 16'h0080, 8'd0, 3'd2, 2'b01, 1'b0);
    check("post_rst_rdata", rbeats[0], 32'hC0FFEE00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
